pokey_pot_scanner: RTL
======================

# pokey_pot_scanner

Multi-channel, parametrised paddle/potentiometer scanner for the POKEY IO section, succeeding the single-channel pot scan FSM. One shared scan counter serves NUM_POTS channels. A POTGO strobe triggers a capacitor-dump phase, then a scan phase in which each channel latches the counter value when its comparator input goes high. The block provides POKEY's ALLPOT status vector and a fast-scan mode. Register decode drives potgo/fast_scan; the line-rate tick comes from the POKEY clock divider.

## Interface
- NUM_POTS, 8, number of pot channels
- CNT_W, 8, width of scan counter and of each captured value
- MAX_COUNT, 228, terminal count; must satisfy MAX_COUNT < 2**CNT_W
- MIN_COUNT, 0, pot_in ignored while counter < MIN_COUNT; must be <= MAX_COUNT
- DUMP_CYCLES, 16, clk cycles pot_dump is asserted; must be >= 1
- clk  in  1  system clock; one clock
- rst  in  1  reset, synchronous, active-high
- pot_in  in  NUM_POTS  comparator inputs, already synchronous to clk; 1 = capacitor charged
- potgo  in  1  single-cycle start strobe (POTGO write)
- fast_scan  in  1  1 = counter steps every clk; 0 = steps on scan_tick
- scan_tick  in  1  single-cycle line-rate enable
- pot_val  out  NUM_POTS*CNT_W  captured values; channel i at bits [i*CNT_W +: CNT_W]
- allpot  out  NUM_POTS  1 = channel still scanning (ALLPOT)
- pot_dump  out  1  discharge command to pot pads
- scan_busy  out  1  high in DUMP or SCAN
- scan_done  out  1  one-cycle pulse on normal scan completion

## Operation
- States: IDLE, DUMP, SCAN. Reset → IDLE. All outputs 0 after reset: pot_val, allpot, pot_dump, scan_busy, scan_done; counter = 0.
- IDLE: counter is held at 0. potgo → DUMP.
- DUMP: pot_dump = 1, allpot = all ones, and the dump counter runs DUMP_CYCLES clocks. After the last dump cycle → SCAN with counter = 0.
- SCAN: step = fast_scan ? 1 : scan_tick. Each clk, every channel with allpot[i] = 1, pot_in[i] = 1 and counter >= MIN_COUNT latches pot_val[i] ← counter and clears allpot[i]. On step, counter increments by 1.
- Capture and increment in the same cycle: the captured value is the pre-increment counter.
- Terminal: on a step while counter == MAX_COUNT, every channel with allpot still 1 latches MAX_COUNT. allpot clears, the state goes to IDLE and scan_done pulses. The counter never wraps.
- Early completion: when the last remaining allpot bit clears, the state goes to IDLE and scan_done pulses on the same edge.
- potgo during DUMP restarts the dump count. potgo during SCAN aborts the scan and enters DUMP with allpot all ones. Channels that did not capture keep their previous pot_val; channels already captured keep the new value.
- potgo coincident with completion: potgo wins, DUMP is entered and there is no scan_done.
- fast_scan is sampled every cycle; a change mid-scan takes effect immediately.
- rst at any point returns to the reset state on the next edge, and pot_val is zeroed.

## Timing
- potgo high at edge T → pot_dump, scan_busy and allpot (all ones) high from T+1 through T+DUMP_CYCLES. SCAN starts at T+DUMP_CYCLES+1 with counter 0.
- All outputs are registered. pot_val[i] and allpot[i] update on the edge that samples the qualifying pot_in[i]: one-cycle latency.
- In fast mode, a channel whose pot_in rises k clocks into SCAN reads k, provided k >= MIN_COUNT and k <= MAX_COUNT.
- scan_done and the deassertion of scan_busy occur on the same edge.

## Structure
- Package pokey_pot_pkg holds:
  - the 2-bit state enum (IDLE=0, DUMP=1, SCAN=2);
  - default parameter constants (8, 228, 16);
  - the value-slicing width rule.
- Sub-module pokey_pot_channel, generated NUM_POTS times. It holds the pot_val register and the allpot bit. Its inputs are counter, capture-enable, force-terminal and start.
- The top level holds the FSM, the scan counter and the dump counter.

## Test plan
- Reset: assert rst mid-SCAN with pot_val[0]=37 → next cycle all outputs 0, state IDLE.
- Fast scan, defaults: potgo; pot_in[i] rises at SCAN cycle 10*i+5 → pot_val = 5,15,…,75, allpot bits clear in order, scan_done one cycle after channel 7 captures, pot_dump high exactly 16 cycles.
- Slow scan: fast_scan=0, scan_tick every 4th clk, pot_in[0] rises after 12 ticks → pot_val[0]=12. Other channels never rise → they read 228, and scan_done pulses on the 229th tick.
- MIN_COUNT=4: pot_in all high from SCAN start → all channels read 4.
- Abort: potgo at SCAN count 50 after channel 2 captured 30 → allpot all ones, pot_dump high 16 cycles, pot_val[2]=30 retained until recaptured, no scan_done.
- Coincidence: potgo on the cycle the last channel captures → DUMP entered, scan_done stays 0.

Source files
------------

// File: rtl/pokey_pot_pkg.sv
// Shared types and defaults for the POKEY pot scanner.
// State encoding, default parameters and the value-vector width rule.
package pokey_pot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_SCAN = 2'd2
  } pot_state_e;

  localparam int DEF_NUM_POTS    = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MAX_COUNT   = 228;
  localparam int DEF_DUMP_CYCLES = 16;

  // Packed pot_val width: one CNT_W field per channel.
  function automatic int pot_vec_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/pokey_pot_channel.sv
// One pot channel: captured value register plus its ALLPOT bit.
// Ports: clk/rst, start_i, cap_i, force_i, cnt_i -> val_o, busy_o.
module pokey_pot_channel
  import pokey_pot_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cap_i,
  input  logic             force_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] val_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] val_q, val_d;
  logic             busy_q, busy_d;
  logic             hit;

  // Terminal force latches the counter too: it equals MAX_COUNT then.
  assign hit = busy_q & (cap_i | force_i);

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q & ~hit;
    if (hit) val_d = cnt_i;
    if (start_i) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
    end
  end

  assign val_o  = val_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/pokey_pot_scanner.sv
// Multi-channel POKEY paddle scanner: dump, then shared-counter scan.
// Ports: pot_in/potgo/fast_scan/scan_tick in; pot_val/allpot/status out.
module pokey_pot_scanner
  import pokey_pot_pkg::*;
#(
  parameter int NUM_POTS    = DEF_NUM_POTS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_COUNT   = DEF_MAX_COUNT,
  parameter int MIN_COUNT   = 0,
  parameter int DUMP_CYCLES = DEF_DUMP_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_POTS-1:0]                   pot_in,
  input  logic                                  potgo,
  input  logic                                  fast_scan,
  input  logic                                  scan_tick,
  output logic [pot_vec_w(NUM_POTS,CNT_W)-1:0] pot_val,
  output logic [NUM_POTS-1:0]                   allpot,
  output logic                                  pot_dump,
  output logic                                  scan_busy,
  output logic                                  scan_done
);

  localparam int DW = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;

  pot_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     dump_q, dump_d;
  logic              dump_o_q, busy_q, done_q, done_d;

  logic              step, in_scan, cap_ok, term, finish;
  logic [NUM_POTS-1:0] cap_en, left;

  assign step    = fast_scan | scan_tick;
  assign in_scan = (state_q == ST_SCAN);
  assign cap_ok  = in_scan && (int'(cnt_q) >= MIN_COUNT);
  assign cap_en  = cap_ok ? pot_in : '0;
  assign term    = in_scan && step &&
                   (cnt_q == CNT_W'(MAX_COUNT));
  assign left    = allpot & ~cap_en;
  // Done either at terminal count or when the last channel captures.
  assign finish  = in_scan && (term || (left == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dump_d  = dump_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (potgo) begin
          state_d = ST_DUMP;
          dump_d  = '0;
        end
      end
      ST_DUMP: begin
        cnt_d = '0;
        if (potgo) begin
          dump_d = '0;
        end else if (dump_q == DW'(DUMP_CYCLES - 1)) begin
          state_d = ST_SCAN;
        end else begin
          dump_d = dump_q + DW'(1);
        end
      end
      ST_SCAN: begin
        if (potgo) begin
          state_d = ST_DUMP;
          dump_d  = '0;
          cnt_d   = '0;
        end else if (finish) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (step) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dump_q   <= '0;
      dump_o_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dump_q   <= dump_d;
      dump_o_q <= (state_d == ST_DUMP);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_POTS; i++) begin : g_ch
    pokey_pot_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .start_i (potgo),
      .cap_i   (cap_en[i]),
      .force_i (term & ~potgo),
      .cnt_i   (cnt_q),
      .val_o   (pot_val[i*CNT_W +: CNT_W]),
      .busy_o  (allpot[i])
    );
  end

  assign pot_dump  = dump_o_q;
  assign scan_busy = busy_q;
  assign scan_done = done_q;

endmodule
